// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one variable-latency memory port between instruction fetch and data.
// Round-robin on ties, one outstanding transaction, registered memory request, optional timeout.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic                    i_read,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_ready,
  output logic                    i_err,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  input  logic                    d_read,
  input  logic                    d_write,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_ready,
  output logic                    d_err,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_read,
  output logic                    m_write,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic                    m_ready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  state_e                  state_q, state_d;
  grant_e                  last_grant_q, last_grant_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0]   m_wdata_q, m_wdata_d;
  logic [STRB_WIDTH-1:0]   m_wstrb_q, m_wstrb_d;
  logic                    m_read_q, m_read_d;
  logic                    m_write_q, m_write_d;

  logic d_req;
  logic grant_i;
  logic grant_d;
  logic busy;
  logic expired;
  logic done;

  assign d_req   = d_read | d_write;
  // On a tie the port that was not served last wins, so each port waits at most one transaction.
  assign grant_i = i_read & (~d_req | (last_grant_q == GRANT_D));
  assign grant_d = d_req & ~grant_i;

  assign busy    = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign expired = (TIMEOUT > 0) && busy && (cnt_q == CNT_LAST);
  assign done    = busy && (m_ready || expired);

  // NOTE: every signal gets a default at the top of always_comb; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_wstrb_d    = m_wstrb_q;
    m_read_d     = m_read_q;
    m_write_d    = m_write_q;

    unique case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d      = BUSY_I;
          last_grant_d = GRANT_I;
          cnt_d        = '0;
          m_addr_d     = i_addr;
          m_wdata_d    = '0;
          m_wstrb_d    = '0;
          m_read_d     = 1'b1;
          m_write_d    = 1'b0;
        end else if (grant_d) begin
          state_d      = BUSY_D;
          last_grant_d = GRANT_D;
          cnt_d        = '0;
          m_addr_d     = d_addr;
          m_wdata_d    = d_wdata;
          m_wstrb_d    = d_wstrb;
          // A simultaneous load and store performs only the store.
          m_read_d     = d_read & ~d_write;
          m_write_d    = d_write;
        end
      end
      BUSY_I, BUSY_D: begin
        if (done) begin
          state_d   = IDLE;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        m_read_d  = 1'b0;
        m_write_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values; this reset is asserted high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      cnt_q        <= '0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_wstrb_q    <= '0;
      m_read_q     <= 1'b0;
      m_write_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_wstrb_q    <= m_wstrb_d;
      m_read_q     <= m_read_d;
      m_write_q    <= m_write_d;
    end
  end

  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wstrb = m_wstrb_q;
  assign m_read  = m_read_q;
  assign m_write = m_write_q;

  // Completion is reported in the same cycle as m_ready; a real response beats an expiring timer.
  assign i_ready = (state_q == BUSY_I) && (m_ready || expired);
  assign i_err   = (state_q == BUSY_I) && !m_ready && expired;
  assign i_rdata = ((state_q == BUSY_I) && m_ready) ? m_rdata : '0;

  assign d_ready = (state_q == BUSY_D) && (m_ready || expired);
  assign d_err   = (state_q == BUSY_D) && !m_ready && expired;
  assign d_rdata = ((state_q == BUSY_D) && m_ready) ? m_rdata : '0;

endmodule
